// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one combinational N x N multiplier among NREQ requesters
//   clk, rst (sync, active-high); req[NREQ]; op_a/op_b[NREQ*N] packed, requester i at [i*N +: N]
//   grant/done[NREQ] one-hot 1-cycle pulses; result[2N] held until next done; busy outside IDLE
//   mult_a/mult_b[N] registered operands to the multiplier; mult_p[2N] its product
//   MULT_PIPE_EN: adds a WAIT state so the product settles for two cycles (period 4 instead of 3)
module mult_arbiter #(
  parameter int N    = 24,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] op_a,
  input  logic [NREQ*N-1:0] op_b,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [2*N-1:0]    result,
  output logic              busy,
  output logic [N-1:0]      mult_a,
  output logic [N-1:0]      mult_b,
  input  logic [2*N-1:0]    mult_p
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef MULT_PIPE_EN
  typedef enum logic [1:0] {IDLE, CALC, WAIT, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif
  state_t state;
  logic [PW-1:0] ptr, w, win, nxt;
  int j;
  always_comb begin
    win = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k >= NREQ) ? int'(ptr) + k - NREQ : int'(ptr) + k;
      win = req[j] ? PW'(j) : win;
    end
    nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      w      <= '0;
      grant  <= '0;
      done   <= '0;
      result <= '0;
      busy   <= 1'b0;
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          mult_a <= op_a[win*N +: N];
          mult_b <= op_b[win*N +: N];
          grant  <= NREQ'(1) << win;
          w      <= win;
          ptr    <= nxt;
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          grant <= '0;
`ifdef MULT_PIPE_EN
          state <= WAIT;
        end
        WAIT: begin
`endif
          result <= mult_p;
          done   <= NREQ'(1) << w;
          state  <= RESP;
        end
        RESP: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
